// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register bank.
package gpr_pkg;

  localparam int unsigned OP_W = 2;

  // Modify operation applied to the register selected by wr_sel.
  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

endpackage : gpr_pkg

// File: rtl/gpr_step.sv
// Combinational next-value and flag computation for one register modify.
module gpr_step
  import gpr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] next_c_o,
  output logic             zero_c_o,
  output logic             carry_c_o
);

  logic [WIDTH-1:0] next_val;
  logic             carry_val;

  // Apply the op; carry flags INC wrap from all-ones and DEC borrow from zero.
  always_comb begin
    next_val  = '0;
    carry_val = 1'b0;
    unique case (op_i)
      OP_LOAD: next_val = data_i;
      OP_INC: begin
        next_val  = cur_i + WIDTH'(1);
        carry_val = (cur_i == {WIDTH{1'b1}});
      end
      OP_DEC: begin
        next_val  = cur_i - WIDTH'(1);
        carry_val = (cur_i == '0);
      end
      OP_CLR:  next_val = '0;
      default: next_val = '0;
    endcase
  end

  assign next_c_o  = next_val;
  assign zero_c_o  = (next_val == '0);
  assign carry_c_o = carry_val;

endmodule : gpr_step

// File: rtl/gpr_bank.sv
// Register bank with one modify port, a tri-stated bus read port and an aux read port.
module gpr_bank
  import gpr_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREGS = 4,
  localparam int unsigned SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [1:0]       op,
  input  logic             rd_en,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic [SEL_W-1:0] aux_sel,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] aux_out,
  output logic             zero,
  output logic             carry
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] aux_q, aux_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] wr_cur;
  logic             wr_hit;
  logic             wr_go;
  logic [WIDTH-1:0] step_next;
  logic             step_zero;
  logic             step_carry;

  // Select muxes; unmatched (out-of-range) indices read 0 and block writes.
  always_comb begin
    wr_cur = '0;
    wr_hit = 1'b0;
    bus_d  = '0;
    aux_d  = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wr_sel == SEL_W'(i)) begin
        wr_cur = regs_q[i];
        wr_hit = 1'b1;
      end
      if (rd_sel == SEL_W'(i)) begin
        bus_d = regs_q[i];
      end
      if (aux_sel == SEL_W'(i)) begin
        aux_d = regs_q[i];
      end
    end
  end

  assign wr_go = wr_en & wr_hit;
  assign oe_d  = rd_en;

  gpr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur_i     (wr_cur),
    .op_i      (op_e'(op)),
    .data_i    (data_in),
    .next_c_o  (step_next),
    .zero_c_o  (step_zero),
    .carry_c_o (step_carry)
  );

  // Next register contents and flags; flags hold unless a valid modify occurs.
  always_comb begin
    regs_d  = regs_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (wr_go) begin
      zero_d  = step_zero;
      carry_d = step_carry;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wr_sel == SEL_W'(i)) begin
          regs_d[i] = step_next;
        end
      end
    end
  end

  // State update; reads sample pre-update contents (read-before-write).
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      bus_q   <= '0;
      oe_q    <= 1'b0;
      aux_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      bus_q   <= bus_d;
      oe_q    <= oe_d;
      aux_q   <= aux_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign data_out = oe_q ? bus_q : {WIDTH{1'bz}};
  assign aux_out  = aux_q;
  assign zero     = zero_q;
  assign carry    = carry_q;

endmodule : gpr_bank

// File: tb/tb_gpr_bank.sv
// Directed self-checking bench for gpr_bank (NREGS=4 and NREGS=3 instances).
module tb_gpr_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default NREGS=4.
  logic       a_clr, a_wr_en, a_rd_en;
  logic [7:0] a_data_in;
  logic [1:0] a_wr_sel, a_rd_sel, a_aux_sel, a_op;
  logic [7:0] a_data_out, a_aux_out;
  logic       a_zero, a_carry;

  // Instance B: NREGS=3, index 3 is out of range.
  logic       b_clr, b_wr_en, b_rd_en;
  logic [7:0] b_data_in;
  logic [1:0] b_wr_sel, b_rd_sel, b_aux_sel, b_op;
  logic [7:0] b_data_out, b_aux_out;
  logic       b_zero, b_carry;

  int vectors = 0;
  int errors  = 0;

  localparam logic [1:0] LD = 2'b00, INC = 2'b01, DEC = 2'b10, CLR = 2'b11;

  gpr_bank #(.WIDTH(8), .NREGS(4)) u_a (
    .clk(clk), .clr(a_clr), .data_in(a_data_in), .wr_en(a_wr_en),
    .wr_sel(a_wr_sel), .op(a_op), .rd_en(a_rd_en), .rd_sel(a_rd_sel),
    .aux_sel(a_aux_sel), .data_out(a_data_out), .aux_out(a_aux_out),
    .zero(a_zero), .carry(a_carry)
  );

  gpr_bank #(.WIDTH(8), .NREGS(3)) u_b (
    .clk(clk), .clr(b_clr), .data_in(b_data_in), .wr_en(b_wr_en),
    .wr_sel(b_wr_sel), .op(b_op), .rd_en(b_rd_en), .rd_sel(b_rd_sel),
    .aux_sel(b_aux_sel), .data_out(b_data_out), .aux_out(b_aux_out),
    .zero(b_zero), .carry(b_carry)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_wr(input logic [1:0] sel, input logic [1:0] o, input logic [7:0] d);
    a_wr_en = 1'b1; a_wr_sel = sel; a_op = o; a_data_in = d;
  endtask

  task automatic b_wr(input logic [1:0] sel, input logic [1:0] o, input logic [7:0] d);
    b_wr_en = 1'b1; b_wr_sel = sel; b_op = o; b_data_in = d;
  endtask

  initial begin
    logic [7:0] zz;
    zz = 8'hzz;
    a_clr = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_data_in = '0;
    a_wr_sel = '0; a_rd_sel = '0; a_aux_sel = '0; a_op = LD;
    b_clr = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_data_in = '0;
    b_wr_sel = '0; b_rd_sel = '0; b_aux_sel = '0; b_op = LD;
    #1;
    tick();
    chk("a_rst_data_out", a_data_out, zz);
    chk("a_rst_aux", a_aux_out, 8'h00);
    chk("a_rst_zero", {7'd0, a_zero}, 8'h00);
    chk("a_rst_carry", {7'd0, a_carry}, 8'h00);
    a_clr = 1'b0; b_clr = 1'b0;

    // LOAD 0xA5 into reg2, then bus read.
    a_wr(2'd2, LD, 8'hA5);
    tick();
    chk("load_zero", {7'd0, a_zero}, 8'h00);
    chk("load_carry", {7'd0, a_carry}, 8'h00);
    a_wr_en = 1'b0; a_rd_en = 1'b1; a_rd_sel = 2'd2;
    tick();
    chk("bus_read_a5", a_data_out, 8'hA5);
    a_rd_en = 1'b0;
    tick();
    chk("bus_read_off", a_data_out, zz);

    // Increment wrap on reg1.
    a_wr(2'd1, LD, 8'hFE);
    tick();
    a_op = INC;
    tick();
    chk("inc1_value_zero", {7'd0, a_zero}, 8'h00);
    chk("inc1_carry", {7'd0, a_carry}, 8'h00);
    a_aux_sel = 2'd1;
    tick();
    chk("inc2_zero", {7'd0, a_zero}, 8'h01);
    chk("inc2_carry", {7'd0, a_carry}, 8'h01);
    chk("inc2_aux_pre", a_aux_out, 8'hFF);
    a_wr_en = 1'b0;
    tick();
    chk("inc2_aux_post", a_aux_out, 8'h00);

    // Decrement borrow on reg3.
    a_wr(2'd3, CLR, 8'h77);
    tick();
    chk("clr_zero", {7'd0, a_zero}, 8'h01);
    chk("clr_carry", {7'd0, a_carry}, 8'h00);
    a_op = DEC;
    tick();
    chk("dec_zero", {7'd0, a_zero}, 8'h00);
    chk("dec_carry", {7'd0, a_carry}, 8'h01);
    a_wr_en = 1'b0; a_aux_sel = 2'd3;
    tick();
    chk("dec_aux", a_aux_out, 8'hFF);
    chk("hold_carry", {7'd0, a_carry}, 8'h01);
    chk("hold_zero", {7'd0, a_zero}, 8'h00);

    // Read/write collision on reg0.
    a_wr(2'd0, LD, 8'h10);
    tick();
    a_data_in = 8'h20; a_rd_en = 1'b1; a_rd_sel = 2'd0;
    tick();
    chk("collide_pre", a_data_out, 8'h10);
    a_wr_en = 1'b0;
    tick();
    chk("collide_post", a_data_out, 8'h20);

    // Reset beats concurrent write and read enables.
    a_clr = 1'b1; a_wr(2'd2, INC, 8'h00); a_rd_en = 1'b1; a_rd_sel = 2'd2;
    tick();
    chk("clr_data_out", a_data_out, zz);
    chk("clr_aux", a_aux_out, 8'h00);
    chk("clr_flag_zero", {7'd0, a_zero}, 8'h00);
    chk("clr_flag_carry", {7'd0, a_carry}, 8'h00);
    a_clr = 1'b0; a_wr_en = 1'b0; a_aux_sel = 2'd1;
    tick();
    chk("clr_reg2", a_data_out, 8'h00);
    chk("clr_reg1", a_aux_out, 8'h00);

    // NREGS=3: out-of-range write and read.
    b_wr(2'd0, LD, 8'h55);
    tick();
    b_wr_sel = 2'd1; b_op = DEC;
    tick();
    chk("b_dec_carry", {7'd0, b_carry}, 8'h01);
    b_wr_sel = 2'd3; b_op = LD; b_data_in = 8'h00;
    tick();
    chk("b_oor_zero_hold", {7'd0, b_zero}, 8'h00);
    chk("b_oor_carry_hold", {7'd0, b_carry}, 8'h01);
    b_wr_en = 1'b0; b_rd_en = 1'b1; b_rd_sel = 2'd3; b_aux_sel = 2'd0;
    tick();
    chk("b_oor_read", b_data_out, 8'h00);
    chk("b_reg0", b_aux_out, 8'h55);
    b_rd_sel = 2'd2; b_aux_sel = 2'd1;
    tick();
    chk("b_reg2", b_data_out, 8'h00);
    chk("b_reg1", b_aux_out, 8'hFF);
    b_rd_en = 1'b0; b_aux_sel = 2'd3;
    tick();
    chk("b_oor_off", b_data_out, zz);
    chk("b_oor_aux", b_aux_out, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_gpr_bank

// File: doc/gpr_bank.md
Name: gpr_bank

Overview:
- Parametrised bank of general-purpose registers for the 8-bit datapath; successor to the single general-purpose register.
- One write/modify port supports load, increment, decrement and single-register clear.
- Two read ports:
  - Registered, tri-stated bus port for the shared system bus.
  - Registered, always-driven auxiliary port feeding the ALU.
- Zero and carry flags are produced for the last modify operation, so one bank replaces the A/B/C registers and loop counters.

Parameters:
- WIDTH, 8, data width of each register and of both read ports.
- NREGS, 4, number of registers; legal range 2..16.
- SEL_W, clog2(NREGS), derived localparam, width of the select fields; not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset.
- data_in  input  WIDTH  load value for op LOAD.
- wr_en  input  1  write/modify enable for the register at wr_sel.
- wr_sel  input  SEL_W  target register index.
- op  input  2  operation: 00 LOAD, 01 INC, 10 DEC, 11 CLR.
- rd_en  input  1  bus output enable.
- rd_sel  input  SEL_W  bus read index.
- aux_sel  input  SEL_W  auxiliary read index.
- data_out  output  WIDTH  registered bus output; high-Z when not enabled.
- aux_out  output  WIDTH  registered auxiliary output, always driven.
- zero  output  1  registered: last modify result == 0.
- carry  output  1  registered: last INC wrapped or last DEC borrowed.

Behaviour:
- Reset (clr=1 at a rising edge):
  - All registers become 0.
  - data_out becomes all-Z; aux_out, zero and carry become 0.
  - clr has priority over wr_en, rd_en and every op, including mid-sequence.
- Modify, when wr_en=1 and clr=0:
  - LOAD: reg = data_in; carry = 0.
  - INC: reg = reg+1 mod 2^WIDTH; carry = 1 only when reg was all-ones.
  - DEC: reg = reg-1 mod 2^WIDTH; carry = 1 only when reg was 0 (borrow).
  - CLR: reg = 0; carry = 0.
  - All ops: zero = (new reg value == 0).
  - Result is visible in the register on the same edge.
- wr_en=0: no register changes; zero and carry hold their values.
- Bus read:
  - At each rising edge, data_out <= reg[rd_sel] if rd_en=1, otherwise all-Z.
  - Latency: 1 cycle from rd_en/rd_sel to data_out.
- Aux read: at each rising edge, aux_out <= reg[aux_sel]; 1-cycle latency.
- Read/write collision on the same edge and same index: read-before-write.
  - The read port returns the pre-update value.
  - The new value appears on the next read.
- Out-of-range select (index >= NREGS when NREGS is not a power of two):
  - Write is ignored and flags hold.
  - A read returns 0 (data_out still Z when rd_en=0).
- Multiple-edge sequences (e.g. INC on consecutive cycles) chain; each edge uses the value written at the previous edge.
- No combinational path from any input to any output.

Decomposition:
- Shared package gpr_pkg:
  - op encodings OP_LOAD, OP_INC, OP_DEC, OP_CLR.
  - Typedef for the 2-bit op field.
  - Shared by the control/sequencer block.
- Sub-module gpr_step:
  - Purely combinational.
  - Inputs: current value, op, data_in.
  - Outputs: next value, zero_next, carry_next.
- gpr_bank holds the register array, the read registers and the flag registers.

Test Plan:
- Reset: after arbitrary writes, assert clr for 1 cycle with wr_en=1 and rd_en=1 -> all regs 0; data_out Z; aux_out=0, zero=0, carry=0 on the next cycle.
- Load and bus read: LOAD 0xA5 into reg2, then rd_en=1 with rd_sel=2 -> data_out=0xA5 one cycle later; with rd_en=0 -> data_out=Z; zero=0, carry=0.
- Increment wrap: LOAD 0xFE into reg1, then INC twice:
  - First INC -> 0xFF, carry=0, zero=0.
  - Second INC -> 0x00, carry=1, zero=1.
- Decrement borrow: CLR reg3, then DEC -> reg3=0xFF, carry=1, zero=0; aux_sel=3 -> aux_out=0xFF one cycle later.
- Collision: reg0=0x10; on the same edge LOAD 0x20 into reg0 with rd_en=1, rd_sel=0 -> data_out=0x10; next read returns 0x20.
- NREGS=3 instance: write with wr_sel=3 -> no register changes, flags hold; rd_sel=3 with rd_en=1 -> data_out=0.
